// File: rtl/tan_cordic.sv
// Iterative tangent: CORDIC rotation for sin/cos, then a restoring divider.
// Angle in unsigned Q16.16 degrees, result in sign-magnitude Q15.16.
module tan_cordic #(
  parameter int K        = 39796,
  parameter int ITER     = 20,
  parameter int DIV_BITS = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] xita,
  output logic        busy,
  output logic        valid,
  output logic [31:0] tan,
  output logic        warn
);

  // x/y carry 13 extra fraction bits; the quotient only sees their ratio
  localparam int GB = 13;
  localparam logic signed [31:0] X0 = 32'(K) <<< GB;
  localparam logic [31:0] DEG90  = 32'h005A_0000;
  localparam logic [31:0] DEG180 = 32'h00B4_0000;
  localparam logic [5:0]  ROT_LAST = 6'(ITER - 1);
  localparam logic [5:0]  DIV_LAST = 6'(DIV_BITS);

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DIV,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [5:0]         cnt;
  logic signed [31:0] x, y, z;
  logic               neg, f_rng, f_zero, f_inf;
  logic [47:0]        dvd;
  logic [31:0]        dvs;
  logic [31:0]        rem;

  logic [31:0]        z_fold;
  logic signed [31:0] xs, ys, atan_i;
  logic [32:0]        rem_sh, rem_sub;
  logic               q_bit;
  logic [31:0]        res_tan;
  logic               res_warn;

  function automatic logic signed [31:0] atan_rom(input logic [4:0] i);
    case (i)
      5'd0:    atan_rom = 32'h002D_0000;
      5'd1:    atan_rom = 32'h001A_90A7;
      5'd2:    atan_rom = 32'h000E_0947;
      5'd3:    atan_rom = 32'h0007_2001;
      5'd4:    atan_rom = 32'h0003_938B;
      5'd5:    atan_rom = 32'h0001_CA38;
      5'd6:    atan_rom = 32'h0000_E52A;
      5'd7:    atan_rom = 32'h0000_7297;
      5'd8:    atan_rom = 32'h0000_394C;
      5'd9:    atan_rom = 32'h0000_1CA6;
      5'd10:   atan_rom = 32'h0000_0E53;
      5'd11:   atan_rom = 32'h0000_0729;
      5'd12:   atan_rom = 32'h0000_0395;
      5'd13:   atan_rom = 32'h0000_01CA;
      5'd14:   atan_rom = 32'h0000_00E5;
      5'd15:   atan_rom = 32'h0000_0073;
      5'd16:   atan_rom = 32'h0000_0039;
      5'd17:   atan_rom = 32'h0000_001D;
      5'd18:   atan_rom = 32'h0000_000E;
      5'd19:   atan_rom = 32'h0000_0007;
      default: atan_rom = 32'h0000_0000;
    endcase
  endfunction

  assign z_fold  = (xita > DEG90) ? DEG180 - xita : xita;
  assign xs      = x >>> cnt[4:0];
  assign ys      = y >>> cnt[4:0];
  assign atan_i  = atan_rom(cnt[4:0]);
  assign rem_sh  = {rem, dvd[47]};
  assign rem_sub = rem_sh - {1'b0, dvs};
  assign q_bit   = ~rem_sub[32];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = ROT;
      ROT:  if (cnt == ROT_LAST) state_nxt = DIV;
      DIV:  if (cnt == DIV_LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_tan  = 32'h0;
    res_warn = 1'b0;
    if (f_rng) begin
      res_warn = 1'b1;
    end else if (f_zero) begin
      res_warn = 1'b0;
    end else if (f_inf || dvs == 32'h0 || |dvd[47:31]) begin
      res_tan  = {neg, 31'h7FFF_FFFF};
      res_warn = 1'b1;
    end else begin
      res_tan = {neg & |dvd[30:0], dvd[30:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      neg    <= 1'b0;
      f_rng  <= 1'b0;
      f_zero <= 1'b0;
      f_inf  <= 1'b0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      valid  <= 1'b0;
      tan    <= '0;
      warn   <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            x      <= X0;
            y      <= '0;
            z      <= signed'(z_fold);
            neg    <= (xita > DEG90);
            f_rng  <= (xita >= DEG180);
            f_zero <= (xita == 32'h0) || (z_fold == 32'h0);
            f_inf  <= (xita == DEG90);
            cnt    <= '0;
          end
        end
        ROT: begin
          if (z[31]) begin
            x <= x + ys;
            y <= y - xs;
            z <= z + atan_i;
          end else begin
            x <= x - ys;
            y <= y + xs;
            z <= z - atan_i;
          end
          cnt <= (cnt == ROT_LAST) ? 6'd0 : cnt + 6'd1;
        end
        DIV: begin
          // first DIV cycle latches the clamped operands
          if (cnt == 6'd0) begin
            dvd <= {(y[31] ? 32'h0 : y), 16'h0};
            dvs <= x[31] ? 32'h0 : x;
            rem <= '0;
          end else begin
            rem <= q_bit ? rem_sub[31:0] : rem_sh[31:0];
            dvd <= {dvd[46:0], q_bit};
          end
          cnt <= cnt + 6'd1;
        end
        DONE: begin
          tan   <= res_tan;
          warn  <= res_warn;
          valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tan_cordic.sv
// Scoreboard bench for tan_cordic: directed angles, specials,
// latency, async reset and start-while-busy behaviour.
module tb_tan_cordic;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] xita;
  logic        busy;
  logic        valid;
  logic [31:0] tan;
  logic        warn;

  always #5 clk = ~clk;

  tan_cordic dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .xita(xita),
    .busy(busy),
    .valid(valid),
    .tan(tan),
    .warn(warn)
  );

  typedef struct {
    string       name;
    logic [31:0] tan;
    int          tol;
    logic        warn;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp_v, int tol);
    int d;
    n_tests++;
    d = int'(got[30:0]) - int'(exp_v[30:0]);
    if (d < 0) d = -d;
    if ($isunknown(got) || got[31] !== exp_v[31] || d > tol) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (tol %0d)",
               name, got, exp_v, tol);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=1 expected none");
      end else begin
        e = sb.pop_front();
        check({e.name, "_lat"}, 32'(cyc - e.acc), 32'd70, 0);
        check({e.name, "_tan"}, tan, e.tan, e.tol);
        check({e.name, "_warn"}, 32'(warn), 32'(e.warn), 0);
        check({e.name, "_busy0"}, 32'(busy), 32'd0, 0);
      end
    end
  end

  task automatic issue(string name, logic [31:0] a, logic [31:0] et,
                       int tol, logic ew, bit now);
    if (!now) @(negedge clk);
    start = 1'b1;
    xita  = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{name, et, tol, ew, cyc});
    check({name, "_busy1"}, 32'(busy), 32'd1, 0);
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no valid expected one", name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 100);
    if (!valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no valid expected one", name);
    end
  endtask

  initial begin
    int nv;
    rst   = 1'b0;
    start = 1'b0;
    xita  = 32'h0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0, 0);
    check("rst_valid", 32'(valid), 32'd0, 0);
    check("rst_tan", tan, 32'd0, 0);
    check("rst_warn", 32'(warn), 32'd0, 0);
    @(negedge clk);
    rst = 1'b0;

    issue("d45", 32'h002D_0000, 32'h0001_0000, 8, 1'b0, 0);
    wait_idle("d45");
    issue("d60", 32'h003C_0000, 32'h0001_BB68, 8, 1'b0, 0);
    wait_idle("d60");
    issue("d30", 32'h001E_0000, 32'h0000_93CD, 8, 1'b0, 0);
    wait_idle("d30");
    issue("d135", 32'h0087_0000, 32'h8001_0000, 8, 1'b0, 0);
    wait_idle("d135");
    issue("d120", 32'h0078_0000, 32'h8001_BB68, 8, 1'b0, 0);
    wait_idle("d120");
    issue("d0", 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 0);
    wait_idle("d0");
    issue("d90", 32'h005A_0000, 32'h7FFF_FFFF, 0, 1'b1, 0);
    wait_idle("d90");
    issue("d180", 32'h00B4_0000, 32'h0000_0000, 0, 1'b1, 0);
    wait_idle("d180");
    issue("bit31", 32'h8000_0000, 32'h0000_0000, 0, 1'b1, 0);
    wait_idle("bit31");

    // leave a nonzero result in place, then abort an operation
    issue("pre_rst", 32'h003C_0000, 32'h0001_BB68, 8, 1'b0, 0);
    wait_idle("pre_rst");
    issue("abort", 32'h002D_0000, 32'h0001_0000, 8, 1'b0, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0, 0);
    check("mid_rst_valid", 32'(valid), 32'd0, 0);
    check("mid_rst_tan", tan, 32'd0, 0);
    check("mid_rst_warn", 32'(warn), 32'd0, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    nv = n_valid;
    repeat (100) @(negedge clk);
    check("no_valid_after_rst", 32'(n_valid), 32'(nv), 0);

    nv = n_valid;
    issue("busy_a", 32'h001E_0000, 32'h0000_93CD, 8, 1'b0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    xita  = 32'h0087_0000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (24) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    xita  = 32'h0087_0000;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid("busy_a");
    issue("b2b", 32'h0078_0000, 32'h8001_BB68, 8, 1'b0, 1);
    wait_idle("b2b");
    repeat (5) @(negedge clk);
    check("busy_valid_count", 32'(n_valid - nv), 32'd2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
